// File: rtl/dff_share_arb.sv
// -----------------------------------------------------------------------------
// dff_share_arb
//   Round-robin arbiter that shares one data register among NREQ requesters.
//   A winner is picked in IDLE, its word is loaded into q in LOAD (with a
//   one-cycle ack/q_valid pulse), and ownership is then held for HOLD_CYC
//   cycles before the pointer moves past the winner and arbitration resumes.
//
// Optional feature macro: SHARE_REG_PARITY_EN
//   When defined, adds input din_par and outputs q_par and par_err.
//   A word whose parity bit disagrees with ^din is rejected.
//
// Parameters
//   W        data word / register width
//   NREQ     number of requesters (2..8)
//   HOLD_CYC cycles ownership is held after the load (>= 1)
//
// Ports
//   clk      rising-edge clock
//   rst      synchronous reset, active-high
//   req      per-requester request level, held until ack
//   din      packed data words, requester i at [i*W +: W]
//   gnt      one-hot grant, all zero when idle
//   ack      one-hot single-cycle pulse: word captured into q
//   q        shared register contents
//   q_valid  single-cycle pulse coincident with ack
//   owner    index of the last captured requester
//   din_par  (SHARE_REG_PARITY_EN) per-requester parity of din
//   q_par    (SHARE_REG_PARITY_EN) registered ^q
//   par_err  (SHARE_REG_PARITY_EN) single-cycle pulse on a rejected word
// -----------------------------------------------------------------------------
module dff_share_arb #(
  parameter int W        = 8,
  parameter int NREQ     = 4,
  parameter int HOLD_CYC = 2,
  localparam int IW      = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int CW      = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] din,
`ifdef SHARE_REG_PARITY_EN
  input  logic [NREQ-1:0]   din_par,
  output logic              q_par,
  output logic              par_err,
`endif
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   ack,
  output logic [W-1:0]      q,
  output logic              q_valid,
  output logic [IW-1:0]     owner
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  state_t        state;
  logic [IW-1:0] ptr;      // first index searched on the next arbitration
  logic [IW-1:0] winner;   // requester currently granted
  logic [CW-1:0] cnt;      // remaining HOLD cycles minus one

  logic          rr_found;
  logic [IW-1:0] rr_idx;
  logic [W-1:0]  win_data;
  logic          par_ok;

  // Index after i, wrapping NREQ-1 -> 0.
  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    if (int'(i) == NREQ - 1) return '0;
    return i + 1'b1;
  endfunction

  // Round-robin search starting at ptr.
  // NOTE: every signal driven here gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    logic [IW:0]   sum;
    logic [IW-1:0] j;
    rr_found = 1'b0;
    rr_idx   = '0;
    sum      = '0;
    j        = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(NREQ)) sum = sum - (IW+1)'(NREQ);
      j = sum[IW-1:0];
      if (!rr_found && req[j]) begin
        rr_found = 1'b1;
        rr_idx   = j;
      end
    end
  end

  assign win_data = din[int'(winner)*W +: W];

`ifdef SHARE_REG_PARITY_EN
  assign par_ok = (din_par[winner] == ^win_data);
`else
  assign par_ok = 1'b1;
`endif

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      ptr     <= '0;
      winner  <= '0;
      cnt     <= '0;
      gnt     <= '0;
      ack     <= '0;
      q       <= '0;
      q_valid <= 1'b0;
      owner   <= '0;
`ifdef SHARE_REG_PARITY_EN
      q_par   <= 1'b0;
      par_err <= 1'b0;
`endif
    end else begin
      // Pulses last exactly one cycle unless re-asserted below.
      ack     <= '0;
      q_valid <= 1'b0;
`ifdef SHARE_REG_PARITY_EN
      par_err <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (rr_found) begin
            winner <= rr_idx;
            gnt    <= ONE << rr_idx;
            state  <= S_LOAD;
          end
        end

        S_LOAD: begin
          if (req[winner] && par_ok) begin
            q       <= win_data;
            owner   <= winner;
            ack     <= ONE << winner;
            q_valid <= 1'b1;
            cnt     <= CW'(HOLD_CYC - 1);
            state   <= S_HOLD;
`ifdef SHARE_REG_PARITY_EN
            q_par   <= ^win_data;
`endif
          end else begin
            // Withdrawn request or bad parity: drop the grant, no capture,
            // and move priority past this requester.
            gnt   <= '0;
            ptr   <= next_idx(winner);
            state <= S_IDLE;
`ifdef SHARE_REG_PARITY_EN
            par_err <= req[winner] && !par_ok;
`endif
          end
        end

        S_HOLD: begin
          if (cnt == '0) begin
            gnt   <= '0;
            ptr   <= next_idx(winner);
            state <= S_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        default: begin
          gnt   <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dff_share_arb.sv
// -----------------------------------------------------------------------------
// tb_dff_share_arb
//   Self-checking bench for dff_share_arb (W=8, NREQ=4, HOLD_CYC=2).
//   Directed sequences push the expected captured word to a scoreboard queue;
//   a negedge monitor pops an entry on every ack/q_valid pulse and compares.
//   Sequence-level timing and grant checks are made in the main process.
// -----------------------------------------------------------------------------
module tb_dff_share_arb;

  localparam int W        = 8;
  localparam int NREQ     = 4;
  localparam int HOLD_CYC = 2;

  typedef struct packed {
    logic [1:0] idx;
    logic [7:0] data;
  } exp_t;

  logic            clk;
  logic            rst;
  logic [NREQ-1:0] req;
  logic [NREQ*W-1:0] din;
  logic [NREQ-1:0] gnt;
  logic [NREQ-1:0] ack;
  logic [W-1:0]    q;
  logic            q_valid;
  logic [1:0]      owner;
`ifdef SHARE_REG_PARITY_EN
  logic [NREQ-1:0] din_par;
  logic            q_par;
  logic            par_err;
`endif

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t sb[$];

  dff_share_arb #(.W(W), .NREQ(NREQ), .HOLD_CYC(HOLD_CYC)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .din     (din),
`ifdef SHARE_REG_PARITY_EN
    .din_par (din_par),
    .q_par   (q_par),
    .par_err (par_err),
`endif
    .gnt     (gnt),
    .ack     (ack),
    .q       (q),
    .q_valid (q_valid),
    .owner   (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Inputs are driven and outputs sampled 1 time unit after the active edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_din(input int i, input logic [7:0] v);
    din[i*W +: W] = v;
  endtask

  task automatic push_exp(input int i, input logic [7:0] v);
    exp_t e;
    e.idx  = 2'(i);
    e.data = v;
    sb.push_back(e);
  endtask

  // Advance until an ack appears; a missing ack counts as a failure.
  task automatic wait_ack(output logic [NREQ-1:0] a, output int c);
    a = '0;
    c = 0;
    for (int n = 0; n < 20; n++) begin
      step(1);
      if (ack != '0) begin
        a = ack;
        c = cyc;
        return;
      end
    end
    check("ack_timeout", 32'(ack), 32'hF);
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 20; n++) begin
      if (gnt == '0) return;
      step(1);
    end
    check("idle_timeout", 32'(gnt), 32'h0);
  endtask

  // Scoreboard monitor: every capture pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && (q_valid || ack != '0)) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_ack", 32'(ack), 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_ack",   32'(ack),     32'(4'b0001 << e.idx));
        check("sb_q",     32'(q),       32'(e.data));
        check("sb_owner", 32'(owner),   32'(e.idx));
        check("sb_qv",    32'(q_valid), 32'h1);
      end
    end
  end

  initial begin
    logic [NREQ-1:0] a;
    int              c;
    int              prev_c;
    int              order[4];

    rst = 1'b1;
    req = 4'hF;
    din = '0;
`ifdef SHARE_REG_PARITY_EN
    din_par = '0;
`endif

    // 1: reset held with all requests up
    step(2);
    check("rst_gnt",   32'(gnt),     32'h0);
    check("rst_ack",   32'(ack),     32'h0);
    check("rst_q",     32'(q),       32'h0);
    check("rst_owner", 32'(owner),   32'h0);
    check("rst_qv",    32'(q_valid), 32'h0);
    req = '0;
    rst = 1'b0;
    step(1);

    // 2: single request, latency and grant duration
    set_din(2, 8'hA5);
    req = 4'b0100;
    push_exp(2, 8'hA5);
    step(1);
    check("t2_gnt",   32'(gnt), 32'h4);
    check("t2_noack", 32'(ack), 32'h0);
    step(1);
    check("t2_ack",   32'(ack),     32'h4);
    check("t2_q",     32'(q),       32'hA5);
    check("t2_qv",    32'(q_valid), 32'h1);
    check("t2_owner", 32'(owner),   32'h2);
    req = '0;
    step(1);
    check("t2_hold_gnt", 32'(gnt),     32'h4);
    check("t2_ack_drop", 32'(ack),     32'h0);
    check("t2_qv_drop",  32'(q_valid), 32'h0);
    check("t2_q_hold",   32'(q),       32'hA5);
    step(1);
    check("t2_gnt_off",  32'(gnt),     32'h0);

    // brief reset so the round-robin pointer starts at 0
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("t3_rst_q", 32'(q), 32'h0);

    // 3: all four requesting, each drops after its ack
    for (int i = 0; i < 4; i++) begin
      set_din(i, 8'(8'h11 * (i + 1)));
      push_exp(i, 8'(8'h11 * (i + 1)));
    end
    req    = 4'hF;
    prev_c = 0;
    for (int i = 0; i < 4; i++) begin
      wait_ack(a, c);
      order[i] = (a == 4'b0001) ? 0 : (a == 4'b0010) ? 1 : (a == 4'b0100) ? 2 : (a == 4'b1000) ? 3 : 9;
      check("t3_order", 32'(order[i]), 32'(i));
      if (i > 0) check("t3_spacing", 32'(c - prev_c), 32'(2 + HOLD_CYC));
      prev_c = c;
      req = req & ~a;
    end
    wait_idle();
    set_din(0, 8'h99);
    req = 4'b0001;
    push_exp(0, 8'h99);
    wait_ack(a, c);
    check("t3_wrap_ack", 32'(a), 32'h1);
    req = '0;
    wait_idle();

    // 4: requester 1 withdraws while its word is being loaded
    set_din(1, 8'h5A);
    set_din(3, 8'h77);
    req = 4'b1010;
    step(1);
    check("t4_gnt1", 32'(gnt), 32'h2);
    req = 4'b1000;
    step(1);
    check("t4_noack",   32'(ack), 32'h0);
    check("t4_gnt_off", 32'(gnt), 32'h0);
    check("t4_q_keep",  32'(q),   32'h99);
    push_exp(3, 8'h77);
    step(1);
    check("t4_gnt3", 32'(gnt), 32'h8);
    step(1);
    check("t4_ack3", 32'(ack), 32'h8);
    check("t4_q3",   32'(q),   32'h77);
    req = '0;
    wait_idle();

    // 5: reset during HOLD while the pointer is non-zero
    set_din(1, 8'h3C);
    req = 4'b0010;
    push_exp(1, 8'h3C);
    wait_ack(a, c);
    check("t5_ack1", 32'(a), 32'h2);
    req = '0;
    wait_idle();
    set_din(2, 8'hC3);
    req = 4'b0100;
    push_exp(2, 8'hC3);
    step(1);
    check("t5_gnt2", 32'(gnt), 32'h4);
    step(1);
    check("t5_ack2", 32'(ack), 32'h4);
    req = 4'b1001;
    step(1);
    rst = 1'b1;
    step(1);
    check("t5_rst_gnt",   32'(gnt),     32'h0);
    check("t5_rst_ack",   32'(ack),     32'h0);
    check("t5_rst_q",     32'(q),       32'h0);
    check("t5_rst_qv",    32'(q_valid), 32'h0);
    check("t5_rst_owner", 32'(owner),   32'h0);
    rst = 1'b0;
    push_exp(0, 8'h99);
    step(1);
    check("t5_gnt0", 32'(gnt), 32'h1);
    step(1);
    check("t5_ack0", 32'(ack), 32'h1);
    req = '0;
    wait_idle();

`ifdef SHARE_REG_PARITY_EN
    // 6: parity rejection then acceptance
    set_din(0, 8'h01);
    din_par = 4'b0000;
    req     = 4'b0001;
    step(1);
    check("t6_gnt", 32'(gnt), 32'h1);
    step(1);
    check("t6_par_err", 32'(par_err), 32'h1);
    check("t6_noack",   32'(ack),     32'h0);
    check("t6_q_keep",  32'(q),       32'h99);
    din_par = 4'b0001;
    push_exp(0, 8'h01);
    wait_ack(a, c);
    check("t6_ack",   32'(a),     32'h1);
    check("t6_q",     32'(q),     32'h01);
    check("t6_q_par", 32'(q_par), 32'h1);
    req = '0;
    wait_idle();
`endif

    step(2);
    check("sb_empty", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
